// File: rtl/if_id_queue_if.sv
// IF/ID boundary bundle: fetch-side packet handshake, decode-side head packet
// and the hazard unit's stall/flush controls.
interface if_id_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic            FlushD;
    logic            StallD;
    logic            validF;
    logic            readyF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] PCPlus4F;
    logic [XLEN-1:0] instrF;
    logic            validD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic [XLEN-1:0] instrD;
    logic [CNTW-1:0] countD;

    modport master (
        output FlushD, StallD, validF, PCF, PCPlus4F, instrF,
        input  readyF, validD, PCD, PCPlus4D, instrD, countD
    );

    modport slave (
        input  FlushD, StallD, validF, PCF, PCPlus4F, instrF,
        output readyF, validD, PCD, PCPlus4D, instrD, countD
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID boundary FIFO of {PC, PC+4, instruction} packets; decode sees a NOP
// bubble whenever the queue is empty.
module if_id_queue #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 2,
    parameter logic [XLEN-1:0] NOP_INSTR  = 32'h00000013,
    parameter bit              BUBBLE_NOP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    if_id_queue_if.slave bus
);
    localparam int CNTW = $clog2(DEPTH + 1);
    // A single-slot queue still needs a 1-bit pointer to stay legal
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [XLEN-1:0] BUBBLE_INSTR = BUBBLE_NOP ? NOP_INSTR : '0;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] pc4_mem   [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [CNTW-1:0] count;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic ready;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNTW'(DEPTH));

    // A full queue may still accept when the head leaves in the same cycle
    assign pop   = !empty && !bus.StallD;
    assign ready = !full || pop;
    assign push  = bus.validF && ready && !bus.FlushD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.FlushD) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Packet storage carries no reset; emptiness is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.PCF;
            pc4_mem[wr_ptr]   <= bus.PCPlus4F;
            instr_mem[wr_ptr] <= bus.instrF;
        end
    end

    always_comb begin
        bus.readyF   = ready;
        bus.validD   = !empty;
        bus.countD   = count;
        bus.PCD      = '0;
        bus.PCPlus4D = '0;
        bus.instrD   = BUBBLE_INSTR;
        if (!empty) begin
            bus.PCD      = pc_mem[rd_ptr];
            bus.PCPlus4D = pc4_mem[rd_ptr];
            bus.instrD   = instr_mem[rd_ptr];
        end
    end

    count_bounded: assert property (@(posedge clk) disable iff (!rst)
        count <= CNTW'(DEPTH));

    rd_ptr_in_range: assert property (@(posedge clk) disable iff (!rst)
        rd_ptr <= PTRW'(DEPTH - 1));

    wr_ptr_in_range: assert property (@(posedge clk) disable iff (!rst)
        wr_ptr <= PTRW'(DEPTH - 1));
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a DEPTH=2 NOP-bubble instance and a
// DEPTH=3 zero-bubble instance checked against a packet queue model.
module tb_if_id_queue;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   check_count;
    int   pass_count;

    if_id_queue_if #(.XLEN(32), .DEPTH(2)) bus_a ();
    if_id_queue_if #(.XLEN(32), .DEPTH(3)) bus_b ();

    if_id_queue #(
        .XLEN(32), .DEPTH(2), .NOP_INSTR(32'h00000013), .BUBBLE_NOP(1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    if_id_queue #(
        .XLEN(32), .DEPTH(3), .NOP_INSTR(32'h00000013), .BUBBLE_NOP(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] pc,
                           input logic stall, input logic flush);
        bus_a.validF   = v;
        bus_a.PCF      = pc;
        bus_a.PCPlus4F = pc + 32'd4;
        bus_a.instrF   = 32'hA000_0000 | pc;
        bus_a.StallD   = stall;
        bus_a.FlushD   = flush;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc, input logic stall);
        bus_b.validF   = v;
        bus_b.PCF      = pc;
        bus_b.PCPlus4F = pc + 32'd4;
        bus_b.instrF   = 32'hB000_0000 | pc;
        bus_b.StallD   = stall;
        bus_b.FlushD   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        drive_b(1'b0, 32'h0, 1'b0);
        check_count++;
        if (bus_a.validD !== 1'b0) $display("[TB] FAIL reset_validD: got %b expected 0", bus_a.validD);
        else pass_count++;
        check_count++;
        if (bus_a.countD !== 2'd0) $display("[TB] FAIL reset_countD: got %0d expected 0", bus_a.countD);
        else pass_count++;
        check_count++;
        if (bus_a.instrD !== 32'h00000013) $display("[TB] FAIL reset_instrD: got %h expected 00000013", bus_a.instrD);
        else pass_count++;
        check_count++;
        if (bus_a.PCD !== 32'h0) $display("[TB] FAIL reset_PCD: got %h expected 0", bus_a.PCD);
        else pass_count++;
        check_count++;
        if (bus_a.readyF !== 1'b1) $display("[TB] FAIL reset_readyF: got %b expected 1", bus_a.readyF);
        else pass_count++;
        check_count++;
        if (bus_b.instrD !== 32'h0) $display("[TB] FAIL reset_b_instrD: got %h expected 0", bus_b.instrD);
        else pass_count++;
        step();
        rst_a = 1'b1;
        rst_b = 1'b1;
    endtask

    task automatic test_pass_through();
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            check_count++;
            if (bus_a.readyF !== 1'b1) $display("[TB] FAIL pass_readyF[%0d]: got %b expected 1", i, bus_a.readyF);
            else pass_count++;
            step();
            check_count++;
            if (bus_a.PCD !== 32'h100 + 32'(4 * i)) $display("[TB] FAIL pass_PCD[%0d]: got %h expected %h", i, bus_a.PCD, 32'h100 + 32'(4 * i));
            else pass_count++;
            check_count++;
            if (bus_a.countD !== 2'd1) $display("[TB] FAIL pass_countD[%0d]: got %0d expected 1", i, bus_a.countD);
            else pass_count++;
            check_count++;
            if (bus_a.instrD !== (32'hA000_0100 + 32'(4 * i))) $display("[TB] FAIL pass_instrD[%0d]: got %h expected %h", i, bus_a.instrD, 32'hA000_0100 + 32'(4 * i));
            else pass_count++;
        end
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check_count++;
        if (bus_a.validD !== 1'b0 || bus_a.instrD !== 32'h00000013) $display("[TB] FAIL pass_drain: got valid=%b instr=%h expected valid=0 instr=00000013", bus_a.validD, bus_a.instrD);
        else pass_count++;
    endtask

    task automatic test_back_pressure();
        drive_a(1'b1, 32'h200, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h204, 1'b1, 1'b0);
        check_count++;
        if (bus_a.readyF !== 1'b1) $display("[TB] FAIL bp_ready_second: got %b expected 1", bus_a.readyF);
        else pass_count++;
        step();
        drive_a(1'b1, 32'h208, 1'b1, 1'b0);
        check_count++;
        if (bus_a.readyF !== 1'b0) $display("[TB] FAIL bp_ready_full: got %b expected 0", bus_a.readyF);
        else pass_count++;
        check_count++;
        if (bus_a.countD !== 2'd2) $display("[TB] FAIL bp_countD_full: got %0d expected 2", bus_a.countD);
        else pass_count++;
        step();
        check_count++;
        if (bus_a.PCD !== 32'h200 || bus_a.countD !== 2'd2) $display("[TB] FAIL bp_hold: got pc=%h count=%0d expected pc=00000200 count=2", bus_a.PCD, bus_a.countD);
        else pass_count++;
        // fetch still holds 0x208 and re-presents it once decode drains
        drive_a(1'b1, 32'h208, 1'b0, 1'b0);
        check_count++;
        if (bus_a.readyF !== 1'b1 || bus_a.PCD !== 32'h200) $display("[TB] FAIL bp_release: got ready=%b pc=%h expected ready=1 pc=00000200", bus_a.readyF, bus_a.PCD);
        else pass_count++;
        step();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        check_count++;
        if (bus_a.PCD !== 32'h204 || bus_a.countD !== 2'd2) $display("[TB] FAIL bp_drain1: got pc=%h count=%0d expected pc=00000204 count=2", bus_a.PCD, bus_a.countD);
        else pass_count++;
        step();
        check_count++;
        if (bus_a.PCD !== 32'h208 || bus_a.PCPlus4D !== 32'h20C) $display("[TB] FAIL bp_drain2: got pc=%h pc4=%h expected pc=00000208 pc4=0000020c", bus_a.PCD, bus_a.PCPlus4D);
        else pass_count++;
        step();
        check_count++;
        if (bus_a.validD !== 1'b0 || bus_a.countD !== 2'd0) $display("[TB] FAIL bp_empty: got valid=%b count=%0d expected valid=0 count=0", bus_a.validD, bus_a.countD);
        else pass_count++;
    endtask

    task automatic test_full_wrap();
        drive_a(1'b1, 32'h300, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h304, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h30C, 1'b0, 1'b0);
        check_count++;
        if (bus_a.readyF !== 1'b1 || bus_a.countD !== 2'd2 || bus_a.PCD !== 32'h300) $display("[TB] FAIL wrap_full_accept: got ready=%b count=%0d pc=%h expected ready=1 count=2 pc=00000300", bus_a.readyF, bus_a.countD, bus_a.PCD);
        else pass_count++;
        step();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        check_count++;
        if (bus_a.PCD !== 32'h304 || bus_a.countD !== 2'd2) $display("[TB] FAIL wrap_second: got pc=%h count=%0d expected pc=00000304 count=2", bus_a.PCD, bus_a.countD);
        else pass_count++;
        step();
        check_count++;
        if (bus_a.PCD !== 32'h30C || bus_a.countD !== 2'd1) $display("[TB] FAIL wrap_third: got pc=%h count=%0d expected pc=0000030c count=1", bus_a.PCD, bus_a.countD);
        else pass_count++;
        step();
        check_count++;
        if (bus_a.validD !== 1'b0) $display("[TB] FAIL wrap_empty: got valid=%b expected 0", bus_a.validD);
        else pass_count++;
    endtask

    task automatic test_flush();
        drive_a(1'b1, 32'h500, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h504, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h400, 1'b1, 1'b1);
        step();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        check_count++;
        if (bus_a.validD !== 1'b0 || bus_a.countD !== 2'd0 || bus_a.PCD !== 32'h0) $display("[TB] FAIL flush_full: got valid=%b count=%0d pc=%h expected valid=0 count=0 pc=0", bus_a.validD, bus_a.countD, bus_a.PCD);
        else pass_count++;
        step();
        check_count++;
        if (bus_a.validD !== 1'b0) $display("[TB] FAIL flush_no_ghost: got valid=%b pc=%h expected valid=0", bus_a.validD, bus_a.PCD);
        else pass_count++;
        // partially full: the flush cycle's push must be dropped even though readyF=1
        drive_a(1'b1, 32'h520, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h404, 1'b0, 1'b1);
        check_count++;
        if (bus_a.readyF !== 1'b1) $display("[TB] FAIL flush_readyF: got %b expected 1", bus_a.readyF);
        else pass_count++;
        step();
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        check_count++;
        if (bus_a.validD !== 1'b0 || bus_a.countD !== 2'd0) $display("[TB] FAIL flush_drop_push: got valid=%b count=%0d pc=%h expected valid=0 count=0", bus_a.validD, bus_a.countD, bus_a.PCD);
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        drive_a(1'b1, 32'h600, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 32'h604, 1'b1, 1'b0);
        step();
        drive_a(1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        rst_a = 1'b0;
        #1;
        check_count++;
        if (bus_a.validD !== 1'b0 || bus_a.countD !== 2'd0) $display("[TB] FAIL mid_reset_state: got valid=%b count=%0d expected valid=0 count=0", bus_a.validD, bus_a.countD);
        else pass_count++;
        check_count++;
        if (bus_a.instrD !== 32'h00000013 || bus_a.PCD !== 32'h0) $display("[TB] FAIL mid_reset_outputs: got instr=%h pc=%h expected instr=00000013 pc=0", bus_a.instrD, bus_a.PCD);
        else pass_count++;
        step();
        rst_a = 1'b1;
        drive_a(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check_count++;
        if (bus_a.validD !== 1'b0) $display("[TB] FAIL mid_reset_after: got valid=%b expected 0", bus_a.validD);
        else pass_count++;
    endtask

    task automatic test_depth3_random();
        logic [31:0] q[$];
        logic [31:0] next_pc;
        logic        stall;
        logic        exp_ready;
        logic        exp_valid;
        int          pushed;
        int          cycles;
        next_pc = 32'h1000;
        pushed  = 0;
        cycles  = 0;
        while ((pushed < 10 || q.size() > 0) && cycles < 200) begin
            stall = 1'($urandom_range(0, 1));
            drive_b(pushed < 10, next_pc, stall);
            exp_valid = (q.size() > 0);
            exp_ready = (q.size() < 3) || (exp_valid && !stall);
            check_count++;
            if (bus_b.readyF !== exp_ready) $display("[TB] FAIL d3_readyF[%0d]: got %b expected %b", cycles, bus_b.readyF, exp_ready);
            else pass_count++;
            check_count++;
            if (int'(bus_b.countD) != q.size()) $display("[TB] FAIL d3_countD[%0d]: got %0d expected %0d", cycles, bus_b.countD, q.size());
            else pass_count++;
            check_count++;
            if (bus_b.validD !== exp_valid) $display("[TB] FAIL d3_validD[%0d]: got %b expected %b", cycles, bus_b.validD, exp_valid);
            else pass_count++;
            if (exp_valid) begin
                check_count++;
                if (bus_b.PCD !== q[0] || bus_b.PCPlus4D !== q[0] + 32'd4) $display("[TB] FAIL d3_head[%0d]: got pc=%h pc4=%h expected pc=%h", cycles, bus_b.PCD, bus_b.PCPlus4D, q[0]);
                else pass_count++;
            end else begin
                check_count++;
                if (bus_b.instrD !== 32'h0 || bus_b.PCD !== 32'h0) $display("[TB] FAIL d3_bubble[%0d]: got instr=%h pc=%h expected 0", cycles, bus_b.instrD, bus_b.PCD);
                else pass_count++;
            end
            if (exp_valid && !stall) void'(q.pop_front());
            if (pushed < 10 && exp_ready) begin
                q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
                pushed++;
            end
            step();
            cycles++;
        end
        if (cycles >= 200) begin
            check_count++;
            $display("[TB] FAIL d3_timeout: got %0d cycles expected fewer than 200", cycles);
        end
        drive_b(1'b0, 32'h0, 1'b0);
        check_count++;
        if (bus_b.validD !== 1'b0 || bus_b.instrD !== 32'h0) $display("[TB] FAIL d3_final: got valid=%b instr=%h expected valid=0 instr=0", bus_b.validD, bus_b.instrD);
        else pass_count++;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_full_wrap();
        test_flush();
        test_reset_mid();
        test_depth3_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
